// File: rtl/mips_pkg.sv
// mips_pkg
// Shared MIPS definitions for the IF/ID fetch control slice: opcode
// constants, the canonical NOP encoding, a packed view of the I-type
// instruction fields, and a helper that says whether an opcode reads rt.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_INST = 32'h0;

    // I-type layout; the J-type target is simply the low 26 bits of the word.
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } inst_fields_t;

    // R-type, branches and stores read rt as a source; loads and jumps do not.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/if_id_fetch_ctrl_if.sv
// if_id_fetch_ctrl_if
// Bundle between the IF stage and the IF/ID fetch controller.
//   IFtoID_PC   : PC+4 of the fetched instruction (IF -> ID)
//   IFtoID_inst : fetched instruction word        (IF -> ID)
//   PCWrite     : PC update enable                (ID -> IF)
//   PCSrc       : select Branch as next PC        (ID -> IF)
//   Branch      : redirect target                 (ID -> IF)
// master = IF stage side, slave = fetch controller side.
interface if_id_fetch_ctrl_if;

    logic [31:0] IFtoID_PC;
    logic [31:0] IFtoID_inst;
    logic        PCWrite;
    logic        PCSrc;
    logic [31:0] Branch;

    modport master (
        output IFtoID_PC,
        output IFtoID_inst,
        input  PCWrite,
        input  PCSrc,
        input  Branch
    );

    modport slave (
        input  IFtoID_PC,
        input  IFtoID_inst,
        output PCWrite,
        output PCSrc,
        output Branch
    );

endinterface

// File: rtl/id_hazard_detect.sv
// id_hazard_detect
// Purely combinational hazard check for the instruction sitting in ID.
//   id_valid_i                 : IF/ID holds a real instruction
//   op_i, rs_i, rt_i           : decoded fields of the ID instruction
//   ex_mem_read_i/ex_reg_write_i/ex_dst_i : EX stage producer info
//   mem_mem_read_i/mem_dst_i   : MEM stage load info
//   stall_o                    : hold fetch and bubble EX this cycle
module id_hazard_detect
    import mips_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [5:0] op_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_dst_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_dst_i,
    output logic       stall_o
);

    logic loadUse;
    logic branchOperand;
    logic isBranch;
    logic exHitsSrc;
    logic memHitsSrc;

    // Branches compare in ID, so they also wait on ALU results still in EX
    // and on loads that have only reached MEM. Register 0 never matches.
    always_comb begin
        isBranch      = (op_i == OP_BEQ) || (op_i == OP_BNE);
        exHitsSrc     = (ex_dst_i != 5'd0) && ((ex_dst_i == rs_i) || (ex_dst_i == rt_i));
        memHitsSrc    = (mem_dst_i != 5'd0) && ((mem_dst_i == rs_i) || (mem_dst_i == rt_i));
        loadUse       = id_valid_i && ex_mem_read_i && (ex_dst_i != 5'd0) &&
                        ((ex_dst_i == rs_i) || (uses_rt(op_i) && (ex_dst_i == rt_i)));
        branchOperand = isBranch && ((ex_reg_write_i && exHitsSrc) ||
                                     (mem_mem_read_i && memHitsSrc));
        stall_o       = loadUse || branchOperand;
    end

endmodule

// File: rtl/if_id_fetch_ctrl.sv
// if_id_fetch_ctrl
// IF/ID pipeline register plus fetch steering. Resolves beq/bne/j in ID,
// stalls on load-use and branch-operand hazards, flushes on redirect.
//   clk, rst                   : clock, synchronous active-high reset
//   fetch (slave)              : IFtoID_PC/IFtoID_inst in, PCWrite/PCSrc/Branch out
//   rs_data, rt_data           : register-file read data for id_inst
//   ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst : hazard info
//   id_pc, id_inst, id_valid   : IF/ID register contents
//   id_bubble                  : zero the controls going into EX
//   stall_count, flush_count   : saturating event counters (CNT_W bits)
module if_id_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    if_id_fetch_ctrl_if.slave   fetch,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,
    input  logic                ex_mem_read,
    input  logic                ex_reg_write,
    input  logic [4:0]          ex_dst,
    input  logic                mem_mem_read,
    input  logic [4:0]          mem_dst,
    output logic [31:0]         id_pc,
    output logic [31:0]         id_inst,
    output logic                id_valid,
    output logic                id_bubble,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
);

    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_inst_q, id_inst_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    inst_fields_t fields;
    logic         stall;
    logic         taken;
    logic [31:0]  branchTgt;
    logic [31:0]  jumpTgt;

    assign fields = inst_fields_t'(id_inst_q);

    id_hazard_detect u_hazard (
        .id_valid_i     (id_valid_q),
        .op_i           (fields.op),
        .rs_i           (fields.rs),
        .rt_i           (fields.rt),
        .ex_mem_read_i  (ex_mem_read),
        .ex_reg_write_i (ex_reg_write),
        .ex_dst_i       (ex_dst),
        .mem_mem_read_i (mem_mem_read),
        .mem_dst_i      (mem_dst),
        .stall_o        (stall)
    );

    // Redirect decision. A stalled branch is not resolved this cycle; it is
    // re-evaluated once its operands are ready.
    always_comb begin
        taken     = 1'b0;
        branchTgt = id_pc_q + {{14{fields.imm[15]}}, fields.imm, 2'b00};
        jumpTgt   = {id_pc_q[31:28], id_inst_q[25:0], 2'b00};
        if (id_valid_q && !stall) begin
            case (fields.op)
                OP_BEQ:  taken = (rs_data == rt_data);
                OP_BNE:  taken = (rs_data != rt_data);
                OP_J:    taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
        fetch.PCWrite = !stall;
        fetch.PCSrc   = taken;
        fetch.Branch  = 32'h0;
        if (taken) begin
            fetch.Branch = (fields.op == OP_J) ? jumpTgt : branchTgt;
        end
        id_bubble = stall;
    end

    // Next IF/ID contents: stall holds, a redirect discards the instruction
    // fetched behind the branch, otherwise load what IF delivered.
    always_comb begin
        id_pc_d    = fetch.IFtoID_PC;
        id_inst_d  = fetch.IFtoID_inst;
        id_valid_d = 1'b1;
        if (stall) begin
            id_pc_d    = id_pc_q;
            id_inst_d  = id_inst_q;
            id_valid_d = id_valid_q;
        end else if (taken) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Reset clears everything, including any stall in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_q     <= 32'h0;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_valid    = id_valid_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// tb_if_id_fetch_ctrl
// Directed bench for if_id_fetch_ctrl. A second instance with 2-bit counters
// shares all stimulus so counter saturation can be observed quickly.
module tb_if_id_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifPc, ifInst, rsData, rtData;
    logic        exMemRead, exRegWrite, memMemRead;
    logic [4:0]  exDst, memDst;

    logic [31:0] idPc, idInst;
    logic        idValid, idBubble;
    logic [31:0] stallCount, flushCount;

    logic [31:0] idPc2, idInst2;
    logic        idValid2, idBubble2;
    logic [1:0]  stallCount2, flushCount2;

    int compared = 0;
    int mismatched = 0;

    if_id_fetch_ctrl_if fif ();
    if_id_fetch_ctrl_if fif2 ();

    assign fif.IFtoID_PC    = ifPc;
    assign fif.IFtoID_inst  = ifInst;
    assign fif2.IFtoID_PC   = ifPc;
    assign fif2.IFtoID_inst = ifInst;

    always #5 clk = ~clk;

    if_id_fetch_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .fetch(fif.slave),
        .rs_data(rsData), .rt_data(rtData),
        .ex_mem_read(exMemRead), .ex_reg_write(exRegWrite), .ex_dst(exDst),
        .mem_mem_read(memMemRead), .mem_dst(memDst),
        .id_pc(idPc), .id_inst(idInst), .id_valid(idValid), .id_bubble(idBubble),
        .stall_count(stallCount), .flush_count(flushCount)
    );

    if_id_fetch_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .fetch(fif2.slave),
        .rs_data(rsData), .rt_data(rtData),
        .ex_mem_read(exMemRead), .ex_reg_write(exRegWrite), .ex_dst(exDst),
        .mem_mem_read(memMemRead), .mem_dst(memDst),
        .id_pc(idPc2), .id_inst(idInst2), .id_valid(idValid2), .id_bubble(idBubble2),
        .stall_count(stallCount2), .flush_count(flushCount2)
    );

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put a given instruction into IF/ID with all hazard inputs quiet.
    task automatic loadInst(input logic [31:0] pc, input logic [31:0] inst);
        exMemRead = 1'b0; exRegWrite = 1'b0; exDst = 5'd0;
        memMemRead = 1'b0; memDst = 5'd0;
        rsData = 32'h0; rtData = 32'h0;
        ifPc = 32'h0; ifInst = 32'h0;
        tick();
        ifPc = pc; ifInst = inst;
        tick();
        ifPc = pc + 32'd4; ifInst = 32'h0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ifPc = 32'h4; ifInst = 32'h8C080004;
        exMemRead = 1'b0; exRegWrite = 1'b0; exDst = 5'd0;
        memMemRead = 1'b0; memDst = 5'd0; rsData = 32'h0; rtData = 32'h0;
        tick();
        tick();
        compared++; if (idValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %0h want 0", idValid); end
        compared++; if (idInst !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_inst: got %08h want 00000000", idInst); end
        compared++; if (fif.PCWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_pcwrite: got %0h want 1", fif.PCWrite); end
        compared++; if (fif.PCSrc !== 1'b0 || fif.Branch !== 32'h0 || idBubble !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_redirect: got src=%0h br=%08h bub=%0h want 0/0/0", fif.PCSrc, fif.Branch, idBubble); end
        compared++; if (stallCount !== 32'd0 || flushCount !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", stallCount, flushCount); end
        rst = 1'b0;
        tick();
        compared++; if (idInst !== 32'h8C080004 || idValid !== 1'b1 || idPc !== 32'h4) begin mismatched++; $display("[TB] FAIL reset_release_load: got %08h v=%0h pc=%08h want 8c080004 v=1 pc=00000004", idInst, idValid, idPc); end
    endtask

    task automatic test_load_use();
        loadInst(32'h8, 32'h01095020);
        exMemRead = 1'b1; exDst = 5'd8; ifPc = 32'hC; ifInst = 32'hDEADBEEF;
        #1;
        compared++; if (fif.PCWrite !== 1'b0 || idBubble !== 1'b1 || fif.PCSrc !== 1'b0) begin mismatched++; $display("[TB] FAIL loaduse_stall: got pcw=%0h bub=%0h src=%0h want 0/1/0", fif.PCWrite, idBubble, fif.PCSrc); end
        tick();
        compared++; if (idInst !== 32'h01095020 || idPc !== 32'h8) begin mismatched++; $display("[TB] FAIL loaduse_hold: got %08h pc=%08h want 01095020 pc=00000008", idInst, idPc); end
        compared++; if (stallCount !== 32'd1) begin mismatched++; $display("[TB] FAIL loaduse_count: got %0d want 1", stallCount); end
        exMemRead = 1'b0;
        #1;
        compared++; if (fif.PCWrite !== 1'b1 || idBubble !== 1'b0) begin mismatched++; $display("[TB] FAIL loaduse_release: got pcw=%0h bub=%0h want 1/0", fif.PCWrite, idBubble); end
        tick();
        compared++; if (idInst !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL loaduse_advance: got %08h want deadbeef", idInst); end
    endtask

    task automatic test_taken_beq();
        loadInst(32'h14, 32'h1109FFFB);
        rsData = 32'd5; rtData = 32'd5; ifPc = 32'h18; ifInst = 32'h12345678;
        #1;
        compared++; if (fif.PCSrc !== 1'b1 || fif.Branch !== 32'h0 || fif.PCWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL beq_taken: got src=%0h br=%08h pcw=%0h want 1/00000000/1", fif.PCSrc, fif.Branch, fif.PCWrite); end
        tick();
        compared++; if (idValid !== 1'b0 || idInst !== 32'h0 || idPc !== 32'h18) begin mismatched++; $display("[TB] FAIL beq_flush: got v=%0h inst=%08h pc=%08h want 0/00000000/00000018", idValid, idInst, idPc); end
        compared++; if (flushCount !== 32'd1) begin mismatched++; $display("[TB] FAIL beq_flush_count: got %0d want 1", flushCount); end
        compared++; if (fif.PCSrc !== 1'b0 || fif.Branch !== 32'h0) begin mismatched++; $display("[TB] FAIL beq_after_flush: got src=%0h br=%08h want 0/00000000", fif.PCSrc, fif.Branch); end
    endtask

    task automatic test_not_taken_bne();
        loadInst(32'h100, 32'h15090003);
        rsData = 32'd7; rtData = 32'd7; ifInst = 32'h012A4020;
        #1;
        compared++; if (fif.PCSrc !== 1'b0 || fif.Branch !== 32'h0 || fif.PCWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL bne_not_taken: got src=%0h br=%08h pcw=%0h want 0/00000000/1", fif.PCSrc, fif.Branch, fif.PCWrite); end
        rtData = 32'd8;
        #1;
        compared++; if (fif.PCSrc !== 1'b1 || fif.Branch !== 32'h10C) begin mismatched++; $display("[TB] FAIL bne_taken: got src=%0h br=%08h want 1/0000010c", fif.PCSrc, fif.Branch); end
        rtData = 32'd7;
        tick();
        compared++; if (idValid !== 1'b1 || idInst !== 32'h012A4020 || flushCount !== 32'd1) begin mismatched++; $display("[TB] FAIL bne_no_flush: got v=%0h inst=%08h fl=%0d want 1/012a4020/1", idValid, idInst, flushCount); end
    endtask

    task automatic test_jump();
        loadInst(32'h40000008, 32'h08000010);
        #1;
        compared++; if (fif.PCSrc !== 1'b1 || fif.Branch !== 32'h40000040 || fif.PCWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL jump_target: got src=%0h br=%08h pcw=%0h want 1/40000040/1", fif.PCSrc, fif.Branch, fif.PCWrite); end
        tick();
        compared++; if (idValid !== 1'b0 || flushCount !== 32'd2) begin mismatched++; $display("[TB] FAIL jump_flush: got v=%0h fl=%0d want 0/2", idValid, flushCount); end
    endtask

    task automatic test_wrap();
        loadInst(32'h4, 32'h1000FFFE);
        #1;
        compared++; if (fif.PCSrc !== 1'b1 || fif.Branch !== 32'hFFFFFFFC) begin mismatched++; $display("[TB] FAIL wrap_target: got src=%0h br=%08h want 1/fffffffc", fif.PCSrc, fif.Branch); end
        rsData = 32'd1;
        #1;
        compared++; if (fif.PCSrc !== 1'b0 || fif.Branch !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_not_taken: got src=%0h br=%08h want 0/00000000", fif.PCSrc, fif.Branch); end
        tick();
    endtask

    task automatic test_back_to_back_stalls();
        loadInst(32'h20, 32'h11090002);
        memMemRead = 1'b1; memDst = 5'd9; rsData = 32'd3; rtData = 32'd3;
        ifPc = 32'h24; ifInst = 32'h0BADF00D;
        #1;
        compared++; if (fif.PCWrite !== 1'b0 || idBubble !== 1'b1 || fif.PCSrc !== 1'b0 || fif.Branch !== 32'h0) begin mismatched++; $display("[TB] FAIL lwbeq_mem_stall: got pcw=%0h bub=%0h src=%0h br=%08h want 0/1/0/00000000", fif.PCWrite, idBubble, fif.PCSrc, fif.Branch); end
        tick();
        compared++; if (idInst !== 32'h11090002 || stallCount !== 32'd2) begin mismatched++; $display("[TB] FAIL lwbeq_hold1: got %08h st=%0d want 11090002/2", idInst, stallCount); end
        memMemRead = 1'b0; exRegWrite = 1'b1; exDst = 5'd9;
        #1;
        compared++; if (fif.PCWrite !== 1'b0 || fif.PCSrc !== 1'b0) begin mismatched++; $display("[TB] FAIL lwbeq_ex_stall: got pcw=%0h src=%0h want 0/0", fif.PCWrite, fif.PCSrc); end
        tick();
        compared++; if (idInst !== 32'h11090002 || stallCount !== 32'd3) begin mismatched++; $display("[TB] FAIL lwbeq_hold2: got %08h st=%0d want 11090002/3", idInst, stallCount); end
        exRegWrite = 1'b0; exDst = 5'd0;
        #1;
        compared++; if (fif.PCSrc !== 1'b1 || fif.Branch !== 32'h28 || fif.PCWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL lwbeq_resolve: got src=%0h br=%08h pcw=%0h want 1/00000028/1", fif.PCSrc, fif.Branch, fif.PCWrite); end
        tick();
        compared++; if (idValid !== 1'b0 || flushCount !== 32'd3) begin mismatched++; $display("[TB] FAIL lwbeq_flush: got v=%0h fl=%0d want 0/3", idValid, flushCount); end
    endtask

    task automatic test_hazard_boundaries();
        loadInst(32'h30, 32'h8D090000);
        exMemRead = 1'b1; exDst = 5'd9;
        #1;
        compared++; if (fif.PCWrite !== 1'b1 || idBubble !== 1'b0) begin mismatched++; $display("[TB] FAIL lw_rt_unused: got pcw=%0h bub=%0h want 1/0", fif.PCWrite, idBubble); end
        exDst = 5'd0;
        #1;
        compared++; if (fif.PCWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL reg0_no_hazard: got pcw=%0h want 1", fif.PCWrite); end
        exDst = 5'd8;
        #1;
        compared++; if (fif.PCWrite !== 1'b0 || idBubble !== 1'b1) begin mismatched++; $display("[TB] FAIL lw_rs_hazard: got pcw=%0h bub=%0h want 0/1", fif.PCWrite, idBubble); end
        exMemRead = 1'b0; exRegWrite = 1'b1;
        #1;
        compared++; if (fif.PCWrite !== 1'b1) begin mismatched++; $display("[TB] FAIL alu_nonbranch: got pcw=%0h want 1", fif.PCWrite); end
        exRegWrite = 1'b0; exDst = 5'd0;
    endtask

    task automatic test_saturation();
        loadInst(32'h40, 32'h01095020);
        exMemRead = 1'b1; exDst = 5'd9;
        #1;
        compared++; if (fif.PCWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL rtype_rt_hazard: got pcw=%0h want 0", fif.PCWrite); end
        tick();
        compared++; if (stallCount !== 32'd4 || stallCount2 !== 2'd3) begin mismatched++; $display("[TB] FAIL stall_saturate: got %0d/%0d want 4/3", stallCount, stallCount2); end
        exMemRead = 1'b0; exDst = 5'd0;
        loadInst(32'h50, 32'h08000000);
        tick();
        compared++; if (flushCount !== 32'd4 || flushCount2 !== 2'd3) begin mismatched++; $display("[TB] FAIL flush_saturate: got %0d/%0d want 4/3", flushCount, flushCount2); end
    endtask

    task automatic test_reset_mid_stall();
        loadInst(32'h60, 32'h01095020);
        exMemRead = 1'b1; exDst = 5'd8;
        #1;
        compared++; if (fif.PCWrite !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_pre: got pcw=%0h want 0", fif.PCWrite); end
        rst = 1'b1;
        tick();
        compared++; if (idValid !== 1'b0 || idInst !== 32'h0 || idPc !== 32'h0) begin mismatched++; $display("[TB] FAIL midreset_regs: got v=%0h inst=%08h pc=%08h want 0/0/0", idValid, idInst, idPc); end
        compared++; if (stallCount !== 32'd0 || flushCount !== 32'd0 || stallCount2 !== 2'd0) begin mismatched++; $display("[TB] FAIL midreset_counters: got %0d/%0d/%0d want 0/0/0", stallCount, flushCount, stallCount2); end
        compared++; if (fif.PCWrite !== 1'b1 || idBubble !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_stall_dropped: got pcw=%0h bub=%0h want 1/0", fif.PCWrite, idBubble); end
        rst = 1'b0; exMemRead = 1'b0; exDst = 5'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_taken_beq();
        test_not_taken_bne();
        test_jump();
        test_wrap();
        test_back_to_back_stalls();
        test_hazard_boundaries();
        test_saturation();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
